// File: rtl/chip8_sprite_draw.sv
// chip8_sprite_draw: Chip-8 64x32 framebuffer writer executing DXYN sprite draws and 00E0 clears.
// Optional macro CHIP8_SPRITE_CLIP_EN: discard off-screen sprite pixels instead of wrapping them.
module chip8_sprite_draw #(
    parameter int MEM_LATENCY = 1
) (
    input  logic          clk50,
    input  logic          reset_n,
    input  logic          start,
    input  logic          clear,
    input  logic [7:0]    x_in,
    input  logic [7:0]    y_in,
    input  logic [3:0]    n_in,
    input  logic [11:0]   i_addr,
    output logic          mem_rd,
    output logic [11:0]   mem_addr,
    input  logic [7:0]    mem_data,
    output logic          busy,
    output logic          done,
    output logic          collision,
    output logic [2047:0] framebuffer
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, CLEAR, DONE} state_t;

    state_t      state, state_nx;
    logic [5:0]  x0;
    logic [4:0]  y0;
    logic [3:0]  n;
    logic [11:0] base;
    logic [4:0]  cnt;
    logic [2:0]  wcnt;
    logic [4:0]  row_y;
    logic [63:0] mask;
    logic [63:0] cur_row;

    assign row_y    = y0 + cnt;
    assign cur_row  = framebuffer[{row_y, 6'd0} +: 64];
    assign mem_rd   = state == FETCH;
    assign mem_addr = base + 12'(cnt);
    assign busy     = state != IDLE;
    assign done     = state == DONE;

    // State register
    always_ff @(posedge clk50 or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;

    // Next-state logic; clear has priority over start in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = clear ? CLEAR : start ? (n_in == 4'd0 ? DONE : FETCH) : IDLE;
            FETCH:   state_nx = MEM_LATENCY == 1 ? DRAW : WAIT;
            WAIT:    state_nx = wcnt == 3'(MEM_LATENCY - 2) ? DRAW : WAIT;
            DRAW:    state_nx = cnt == {1'b0, n - 4'd1} ? DONE : FETCH;
            CLEAR:   state_nx = cnt == 5'd31 ? DONE : CLEAR;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Place the fetched sprite byte onto a 64-pixel row mask, MSB leftmost
    always_comb begin
        mask = '0;
        for (int b = 0; b < 8; b++) begin
`ifdef CHIP8_SPRITE_CLIP_EN
            if (mem_data[b] && ({1'b0, x0} + 7'(7 - b)) < 7'd64 && ({1'b0, y0} + {1'b0, cnt}) < 6'd32)
                mask[x0 + 6'(7 - b)] = 1'b1;
`else
            if (mem_data[b])
                mask[x0 + 6'(7 - b)] = 1'b1;
`endif
        end
    end

    // Command latch, row/wait counters, framebuffer XOR and row clearing
    always_ff @(posedge clk50 or negedge reset_n)
        if (!reset_n) begin
            x0          <= '0;
            y0          <= '0;
            n           <= '0;
            base        <= '0;
            cnt         <= '0;
            wcnt        <= '0;
            collision   <= 1'b0;
            framebuffer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start && !clear) begin
                        x0        <= 6'(x_in % 8'd64);
                        y0        <= 5'(y_in % 8'd32);
                        n         <= n_in;
                        base      <= i_addr;
                        collision <= 1'b0;
                    end
                end
                FETCH: wcnt <= '0;
                WAIT:  wcnt <= wcnt + 3'd1;
                DRAW: begin
                    framebuffer[{row_y, 6'd0} +: 64] <= cur_row ^ mask;
                    if (|(cur_row & mask)) collision <= 1'b1;
                    cnt <= cnt + 5'd1;
                end
                CLEAR: begin
                    framebuffer[{cnt, 6'd0} +: 64] <= '0;
                    cnt <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_chip8_sprite_draw.sv
// tb_chip8_sprite_draw: directed table and randomized checks of chip8_sprite_draw against a pixel-level model.
module tb_chip8_sprite_draw;
    localparam int LAT = 1;

    logic          clk50 = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [7:0]    x_in = '0;
    logic [7:0]    y_in = '0;
    logic [3:0]    n_in = '0;
    logic [11:0]   i_addr = '0;
    logic          mem_rd;
    logic [11:0]   mem_addr;
    logic [7:0]    mem_data;
    logic          busy;
    logic          done;
    logic          collision;
    logic [2047:0] framebuffer;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    mem [4096];
    logic [11:0]   pipe [LAT];
    logic [2047:0] fb_m = '0;
    logic          coll_m = 1'b0;
    logic [11:0]   rdq [$];

    typedef struct {
        logic       s;
        logic       c;
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] n;
        logic [11:0] ia;
        int         dcyc;
        logic       coll;
    } vec_t;

    vec_t tbl [7];

    chip8_sprite_draw #(.MEM_LATENCY(LAT)) dut (
        .clk50(clk50), .reset_n(reset_n), .start(start), .clear(clear),
        .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_addr(i_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .done(done), .collision(collision), .framebuffer(framebuffer)
    );

    always #10 clk50 = ~clk50;

    always @(posedge clk50) begin
        for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k - 1];
        pipe[0] <= mem_addr;
    end
    assign mem_data = mem[pipe[LAT - 1]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [2047:0] exp);
        int first;
        checks++;
        if (framebuffer !== exp) begin
            errors++;
            first = -1;
            for (int i = 2047; i >= 0; i--) if (framebuffer[i] !== exp[i]) first = i;
            $display("FAIL %s: framebuffer bit %0d got %0b expected %0b", name, first, framebuffer[first], exp[first]);
        end
    endtask

    // Reference: plain pixel-by-pixel sprite XOR from the Chip-8 drawing rules
    task automatic model_cmd(input logic s, input logic c, input logic [7:0] x, input logic [7:0] y,
                             input logic [3:0] n, input logic [11:0] ia);
        logic [7:0] bt;
        int ux, uy, idx;
        if (c) fb_m = '0;
        else if (s) begin
            coll_m = 1'b0;
            for (int r = 0; r < int'(n); r++) begin
                bt = mem[12'(int'(ia) + r)];
                for (int k = 0; k < 8; k++) begin
                    if (bt[7 - k]) begin
                        ux = int'(x) % 64 + k;
                        uy = int'(y) % 32 + r;
`ifdef CHIP8_SPRITE_CLIP_EN
                        if (ux >= 64 || uy >= 32) continue;
`endif
                        idx = (uy % 32) * 64 + ux % 64;
                        if (fb_m[idx]) coll_m = 1'b1;
                        fb_m[idx] = ~fb_m[idx];
                    end
                end
            end
        end
    endtask

    task automatic do_cmd(input string tag, input logic s, input logic c, input logic [7:0] x,
                          input logic [7:0] y, input logic [3:0] n, input logic [11:0] ia,
                          input logic hold, input int exp_done);
        int dcyc, bad, exp_rds;
        @(negedge clk50);
        start = s; clear = c; x_in = x; y_in = y; n_in = n; i_addr = ia;
        rdq.delete();
        dcyc = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk50);
            if (hold) begin
                x_in = 8'($urandom); y_in = 8'($urandom); n_in = 4'($urandom); i_addr = 12'($urandom);
            end else begin
                start = 1'b0; clear = 1'b0;
            end
            if (k == 1) chk({tag, " busy cycle1"}, 64'(busy), 64'd1);
            if (mem_rd) rdq.push_back(mem_addr);
            if (done) begin
                dcyc = k;
                break;
            end
        end
        start = 1'b0; clear = 1'b0;
        model_cmd(s, c, x, y, n, ia);
        chk({tag, " done cycle"}, 64'(dcyc), 64'(exp_done));
        exp_rds = (c || !s) ? 0 : int'(n);
        chk({tag, " read count"}, 64'(rdq.size()), 64'(exp_rds));
        bad = 0;
        foreach (rdq[j]) if (rdq[j] !== 12'(int'(ia) + j)) bad++;
        chk({tag, " read addrs"}, 64'(bad), 64'd0);
        chk({tag, " collision"}, 64'(collision), 64'(coll_m));
        chk_vec({tag, " framebuffer"}, fb_m);
        @(negedge clk50);
        chk({tag, " idle after done"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        logic [2047:0] ev;
        logic          rs, rc, rh;
        logic [7:0]    rx, ry;
        logic [3:0]    rn;
        logic [11:0]   ria;

        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
        mem[12'h100] = 8'hFF; mem[12'h101] = 8'h80;

        tbl[0] = '{1'b1, 1'b0, 8'd0,  8'd0,  4'd5, 12'h050, 11, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'd0,  8'd0,  4'd5, 12'h050, 11, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 8'd62, 8'd31, 4'd1, 12'h100, 3,  1'b0};
        tbl[3] = '{1'b1, 1'b0, 8'd70, 8'd33, 4'd1, 12'h101, 3,  1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'd62, 8'd31, 4'd1, 12'h100, 3,  1'b1};
        tbl[5] = '{1'b1, 1'b1, 8'd0,  8'd0,  4'd5, 12'h050, 33, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 8'd3,  8'd4,  4'd0, 12'h050, 1,  1'b0};

        #15;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset mem_rd", 64'(mem_rd), 64'd0);
        chk("reset mem_addr", 64'(mem_addr), 64'd0);
        chk("reset collision", 64'(collision), 64'd0);
        chk_vec("reset framebuffer", '0);
        @(negedge clk50);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_cmd($sformatf("vec%0d", i), tbl[i].s, tbl[i].c, tbl[i].x, tbl[i].y, tbl[i].n, tbl[i].ia, 1'b0, tbl[i].dcyc);
            chk($sformatf("vec%0d table collision", i), 64'(collision), 64'(tbl[i].coll));
            if (i == 0) begin
                ev = '0;
                ev[0] = 1; ev[1] = 1; ev[2] = 1; ev[3] = 1; ev[64] = 1; ev[67] = 1; ev[128] = 1; ev[131] = 1;
                ev[192] = 1; ev[195] = 1; ev[256] = 1; ev[257] = 1; ev[258] = 1; ev[259] = 1;
                chk_vec("font pixels", ev);
            end
            if (i == 2) begin
                ev = '0;
                ev[2046] = 1; ev[2047] = 1;
`ifndef CHIP8_SPRITE_CLIP_EN
                for (int k = 1984; k <= 1989; k++) ev[k] = 1;
`endif
                chk_vec("wrap pixels", ev);
            end
            if (i == 3) chk("coord reduction bit70", 64'(framebuffer[70]), 64'd1);
        end

        @(negedge clk50);
        start = 1'b1; x_in = 8'd0; y_in = 8'd0; n_in = 4'd15; i_addr = 12'h050;
        @(negedge clk50);
        start = 1'b0;
        repeat (6) @(negedge clk50);
        chk("drawing before reset", 64'(|framebuffer), 64'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset mem_rd", 64'(mem_rd), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        chk("midreset collision", 64'(collision), 64'd0);
        chk_vec("midreset framebuffer", '0);
        @(negedge clk50);
        reset_n = 1'b1;
        fb_m = '0;
        coll_m = 1'b0;
        do_cmd("after reset", 1'b1, 1'b0, 8'd0, 8'd0, 4'd5, 12'h050, 1'b0, 11);

        rx = 0; ry = 0; rn = 1; ria = 0;
        for (int i = 0; i < 40; i++) begin
            rc = $urandom_range(7) == 0;
            rs = rc ? 1'($urandom_range(1)) : 1'b1;
            rh = 1'($urandom_range(1));
            if (!($urandom_range(2) == 0 && i > 0)) begin
                rx = 8'($urandom); ry = 8'($urandom); rn = 4'($urandom); ria = 12'($urandom);
            end
            do_cmd($sformatf("rand%0d", i), rs, rc, rx, ry, rn, ria, rh,
                   rc ? 33 : (rn == 0 ? 1 : int'(rn) * (1 + LAT) + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
